// File: rtl/matmul_pkg.sv
// matmul_pkg: shared defaults, state encoding and helpers for the result path.
// The CHK state exists only when RESULT_CHECKSUM_EN is defined.
package matmul_pkg;

    localparam int ELEM_W_DEF  = 16;
    localparam int MAX_DIM_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
`ifdef RESULT_CHECKSUM_EN
        S_CHK,
`endif
        S_FIN
    } state_t;

    function automatic int byte_count(
        input int n,
        input int elem_w
    );
        return n * n * elem_w / 8;
    endfunction

endpackage

// File: rtl/result_serializer_if.sv
// result_serializer_if: load/result capture side plus the uart_tx byte handshake.
// slave = serializer, master = producer/uart side.
interface result_serializer_if
    import matmul_pkg::*;
#(
    parameter int ELEM_W  = ELEM_W_DEF,
    parameter int MAX_DIM = MAX_DIM_DEF
);
    logic                              load;
    logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] result;
    logic [3:0]                        matrix_size;
    logic                              tx_busy;
    logic                              tx_start;
    logic [7:0]                        tx_data;
    logic                              busy;
    logic                              done;
    logic                              err;

    modport master (
        output load, result, matrix_size, tx_busy,
        input  tx_start, tx_data, busy, done, err
    );

    modport slave (
        input  load, result, matrix_size, tx_busy,
        output tx_start, tx_data, busy, done, err
    );
endinterface

// File: rtl/result_byte_mux.sv
// result_byte_mux: selects byte b (0 = MSB) of element r*MAX_DIM+c from
// the captured result matrix.
module result_byte_mux
    import matmul_pkg::*;
#(
    parameter int ELEM_W  = ELEM_W_DEF,
    parameter int MAX_DIM = MAX_DIM_DEF
) (
    input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] shadow,
    input  logic [3:0]                        r,
    input  logic [3:0]                        c,
    input  logic [3:0]                        b,
    output logic [7:0]                        data
);
    localparam int NB = ELEM_W / 8;

    logic [ELEM_W-1:0] elem;

    always_comb begin
        elem = '0;
        for (int k = 0; k < MAX_DIM * MAX_DIM; k++)
            if (int'(r) * MAX_DIM + int'(c) == k)
                elem = shadow[k*ELEM_W +: ELEM_W];
    end

    always_comb begin
        data = '0;
        for (int i = 0; i < NB; i++)
            if (int'(b) == NB - 1 - i)
                data = elem[i*8 +: 8];
    end
endmodule

// File: rtl/result_serializer.sv
// result_serializer: captures the result matrix on load and streams the active
// n x n elements MSB-first to uart_tx. RESULT_CHECKSUM_EN appends an XOR byte.
module result_serializer
    import matmul_pkg::*;
#(
    parameter int ELEM_W      = ELEM_W_DEF,
    parameter int MAX_DIM     = MAX_DIM_DEF,
    parameter int ACK_TIMEOUT = 15
) (
    input logic                bclk,
    input logic                rst,
    result_serializer_if.slave bus
);
    localparam int         RES_W    = ELEM_W * MAX_DIM * MAX_DIM;
    localparam logic [3:0] LAST_B   = 4'(ELEM_W / 8 - 1);
    localparam logic [3:0] DIM      = 4'(MAX_DIM);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t           state, nstate;
    logic [RES_W-1:0] shadow;
    logic [3:0]       n, n_in, r, c, b;
    logic [7:0]       tmo;
    logic             retry, tx_start_q, err_q, in_chk;
    logic [7:0]       tx_data_q, mux_byte, issue_byte;
    logic             take, issue, adv, tmo_hit, last, err_d;

    result_byte_mux #(
        .ELEM_W  (ELEM_W),
        .MAX_DIM (MAX_DIM)
    ) u_mux (
        .shadow (shadow),
        .r      (r),
        .c      (c),
        .b      (b),
        .data   (mux_byte)
    );

`ifdef RESULT_CHECKSUM_EN
    logic [7:0] xsum;
    assign issue_byte = in_chk ? xsum : mux_byte;
`else
    assign in_chk     = 1'b0;
    assign issue_byte = mux_byte;
`endif

    assign n_in = (bus.matrix_size > DIM) ? DIM : bus.matrix_size;
    assign last = (b == LAST_B) && (c == n - 4'd1)
               && (r == n - 4'd1);
    assign err_d = tmo_hit || (bus.load && state != S_IDLE);

    always_comb begin
        nstate  = state;
        take    = 1'b0;
        issue   = 1'b0;
        adv     = 1'b0;
        tmo_hit = 1'b0;
        unique case (state)
            S_IDLE: if (bus.load) begin
                take   = 1'b1;
                nstate = (n_in == 4'd0) ? S_FIN : S_ISSUE;
            end
            S_ISSUE: if (!bus.tx_busy) begin
                issue  = 1'b1;
                nstate = S_WAIT_ACK;
            end
            S_WAIT_ACK: if (bus.tx_busy) begin
                nstate = S_WAIT_DONE;
            end else if (tmo == TMO_LAST) begin
                tmo_hit = 1'b1;
                if (retry)
                    nstate = S_IDLE;
`ifdef RESULT_CHECKSUM_EN
                else if (in_chk)
                    nstate = S_CHK;
`endif
                else
                    nstate = S_ISSUE;
            end
            S_WAIT_DONE: if (!bus.tx_busy) begin
                if (in_chk) begin
                    nstate = S_FIN;
                end else begin
                    adv = 1'b1;
`ifdef RESULT_CHECKSUM_EN
                    nstate = last ? S_CHK : S_ISSUE;
`else
                    nstate = last ? S_FIN : S_ISSUE;
`endif
                end
            end
`ifdef RESULT_CHECKSUM_EN
            S_CHK: if (!bus.tx_busy) begin
                issue  = 1'b1;
                nstate = S_WAIT_ACK;
            end
`endif
            S_FIN: nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shadow     <= '0;
            n          <= '0;
            r          <= '0;
            c          <= '0;
            b          <= '0;
            tmo        <= '0;
            retry      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= nstate;
            tx_start_q <= issue;
            err_q      <= err_d;
            if (take) begin
                shadow <= bus.result;
                n      <= n_in;
                r      <= '0;
                c      <= '0;
                b      <= '0;
                retry  <= 1'b0;
            end
            if (issue) begin
                tx_data_q <= issue_byte;
                tmo       <= '0;
            end
            if (state == S_WAIT_ACK) begin
                if (bus.tx_busy)
                    retry <= 1'b0;
                else if (tmo_hit)
                    retry <= 1'b1;
                else
                    tmo <= tmo + 8'd1;
            end
            // row-major walk: byte, then column, then row
            if (adv) begin
                if (b == LAST_B) begin
                    b <= '0;
                    if (c == n - 4'd1) begin
                        c <= '0;
                        r <= r + 4'd1;
                    end else begin
                        c <= c + 4'd1;
                    end
                end else begin
                    b <= b + 4'd1;
                end
            end
        end
    end

`ifdef RESULT_CHECKSUM_EN
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            xsum   <= '0;
            in_chk <= 1'b0;
        end else if (take) begin
            xsum   <= '0;
            in_chk <= 1'b0;
        end else if (adv) begin
            xsum <= xsum ^ tx_data_q;
            if (last)
                in_chk <= 1'b1;
        end
    end
`endif

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = !(state == S_IDLE || state == S_FIN);
    assign bus.done     = (state == S_FIN);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: table vectors, random frames against a byte-stream
// model, and hand sequences for retry/abort, mid-frame load and reset.
module tb_result_serializer;
    import matmul_pkg::*;

    localparam int EW  = 16;
    localparam int MD  = 3;
    localparam int TMO = 15;
    localparam int RW  = EW * MD * MD;

    logic bclk = 1'b0;
    logic rst;
    always #5 bclk = ~bclk;

    result_serializer_if #(.ELEM_W(EW), .MAX_DIM(MD)) bus();

    result_serializer #(
        .ELEM_W      (EW),
        .MAX_DIM     (MD),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .bclk (bclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        logic [RW-1:0] res;
        logic [3:0]    ms;
        int            exp_len;
        logic [7:0]    exp_last;
    } vec_t;

    vec_t       tbl[4];
    int         n_vec = 0;
    int         n_bad = 0;
    logic       dead = 1'b0;
    logic [7:0] rx_log[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         proto_bad = 0;
    int         bcnt = 0;

    always @(negedge bclk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1) err_cnt++;
    end

    // uart_tx model: busy for 1..4 cycles per accepted byte
    always @(negedge bclk) begin
        if (rst) begin
            bus.tx_busy = 1'b0;
            bcnt = 0;
        end else if (bus.tx_start === 1'b1) begin
            if (bcnt > 0) proto_bad++;
            rx_log.push_back(bus.tx_data);
            if (!dead) begin
                bus.tx_busy = 1'b1;
                bcnt = $urandom_range(1, 4);
            end
        end else if (bcnt > 0) begin
            if (bus.tx_data !== rx_log[$]) proto_bad++;
            bcnt--;
            if (bcnt == 0) bus.tx_busy = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic build_exp(input logic [RW-1:0] res, input int ms);
        int n;
        logic [7:0] x;
        logic [EW-1:0] e;
        exp_q.delete();
        x = '0;
        n = (ms > MD) ? MD : ms;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                e = res[(r*MD+c)*EW +: EW];
                for (int k = EW/8 - 1; k >= 0; k--) begin
                    exp_q.push_back(8'(e >> (8*k)));
                    x = x ^ 8'(e >> (8*k));
                end
            end
`ifdef RESULT_CHECKSUM_EN
        if (n > 0) exp_q.push_back(x);
`endif
    endtask

    task automatic pulse_load(input logic [RW-1:0] res, input logic [3:0] ms);
        bus.result = res;
        bus.matrix_size = ms;
        bus.load = 1'b1;
        @(negedge bclk);
        bus.load = 1'b0;
        bus.result = ~res;
        bus.matrix_size = ~ms;
    endtask

    task automatic wait_end();
        int i;
        i = 0;
        while (bus.busy === 1'b1 && i < 2000) begin
            @(negedge bclk);
            i++;
        end
        check("frame_end_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge bclk);
    endtask

    task automatic check_stream(input int n0);
        check("byte_count", 32'(rx_log.size() - n0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && n0 + i < rx_log.size(); i++)
            check($sformatf("byte[%0d]", i), 32'(rx_log[n0+i]), 32'(exp_q[i]));
    endtask

    task automatic run_vec(input int v);
        int n0, d0, e0;
        build_exp(tbl[v].res, int'(tbl[v].ms));
        n0 = rx_log.size();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_load(tbl[v].res, tbl[v].ms);
        check("busy_after_load", 32'(bus.busy), 32'(tbl[v].exp_len != 0));
        check("done_after_load", 32'(bus.done), 32'(tbl[v].exp_len == 0));
        check("tx_start_lat1", 32'(bus.tx_start), 32'd0);
        @(negedge bclk);
        check("tx_start_lat2", 32'(bus.tx_start), 32'(tbl[v].exp_len != 0));
        wait_end();
        check("tbl_len", 32'(rx_log.size() - n0), 32'(tbl[v].exp_len));
        if (tbl[v].exp_len > 0 && rx_log.size() > n0)
            check("tbl_last", 32'(rx_log[$]), 32'(tbl[v].exp_last));
        check_stream(n0);
        check("done_cnt", 32'(done_cnt - d0), 32'd1);
        check("err_cnt", 32'(err_cnt - e0), 32'd0);
    endtask

    initial begin
        int n0, d0, e0, i;
        logic [RW-1:0] res;
        logic [3:0] ms;

        tbl[0].res = '0;
        tbl[0].res[0*EW +: EW] = 16'h0102;
        tbl[0].res[1*EW +: EW] = 16'h0304;
        tbl[0].res[2*EW +: EW] = 16'hDEAD;
        tbl[0].res[3*EW +: EW] = 16'h0506;
        tbl[0].res[4*EW +: EW] = 16'h0708;
        tbl[0].ms = 4'd2;
        tbl[1].res = '0;
        for (int k = 0; k < MD*MD; k++)
            tbl[1].res[k*EW +: EW] = 16'hA000 + 16'(k);
        tbl[1].ms = 4'd3;
        tbl[2].res = tbl[1].res;
        tbl[2].ms = 4'd5;
        tbl[3].res = ~tbl[1].res;
        tbl[3].ms = 4'd0;
`ifdef RESULT_CHECKSUM_EN
        tbl[0].exp_len = 9;  tbl[0].exp_last = 8'h08;
        tbl[1].exp_len = 19; tbl[1].exp_last = 8'hA8;
        tbl[2].exp_len = 19; tbl[2].exp_last = 8'hA8;
`else
        tbl[0].exp_len = 8;  tbl[0].exp_last = 8'h08;
        tbl[1].exp_len = 18; tbl[1].exp_last = 8'h08;
        tbl[2].exp_len = 18; tbl[2].exp_last = 8'h08;
`endif
        tbl[3].exp_len = 0;  tbl[3].exp_last = 8'h00;

        rst = 1'b1;
        bus.load = 1'b0;
        bus.result = '0;
        bus.matrix_size = '0;
        repeat (3) @(negedge bclk);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge bclk);

        for (int v = 0; v < 4; v++) run_vec(v);

        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < MD*MD; k++)
                res[k*EW +: EW] = 16'($urandom);
            ms = 4'($urandom_range(0, 6));
            build_exp(res, int'(ms));
            n0 = rx_log.size();
            d0 = done_cnt;
            e0 = err_cnt;
            pulse_load(res, ms);
            wait_end();
            check_stream(n0);
            check("rand_done", 32'(done_cnt - d0), 32'd1);
            check("rand_err", 32'(err_cnt - e0), 32'd0);
        end

        // load mid-frame: ignored with err, original bytes continue
        build_exp(tbl[1].res, 3);
        n0 = rx_log.size();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_load(tbl[1].res, 4'd3);
        i = 0;
        while (rx_log.size() - n0 < 4 && i < 500) begin
            @(negedge bclk);
            i++;
        end
        pulse_load(~tbl[1].res, 4'd2);
        wait_end();
        check_stream(n0);
        check("midload_err", 32'(err_cnt - e0), 32'd1);
        check("midload_done", 32'(done_cnt - d0), 32'd1);

        // dead uart: timeout, one retry of the same byte, then abort
        dead = 1'b1;
        n0 = rx_log.size();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_load(tbl[0].res, 4'd2);
        i = 0;
        while (bus.err !== 1'b1 && i < 100) begin
            @(negedge bclk);
            i++;
        end
        check("err_latency", 32'(i), 32'(TMO + 1));
        wait_end();
        check("dead_err", 32'(err_cnt - e0), 32'd2);
        check("dead_done", 32'(done_cnt - d0), 32'd0);
        check("dead_tries", 32'(rx_log.size() - n0), 32'd2);
        if (rx_log.size() - n0 == 2) begin
            check("dead_b0", 32'(rx_log[n0]), 32'h01);
            check("dead_b1", 32'(rx_log[n0+1]), 32'h01);
        end
        dead = 1'b0;
        repeat (2) @(negedge bclk);

        // reset while the fifth byte is being requested
        n0 = rx_log.size();
        d0 = done_cnt;
        pulse_load(tbl[1].res, 4'd3);
        i = 0;
        while (rx_log.size() - n0 < 5 && i < 500) begin
            @(negedge bclk);
            i++;
        end
        check("reach_byte5", 32'(rx_log.size() - n0), 32'd5);
        rst = 1'b1;
        #1;
        check("rst_mid_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        @(negedge bclk);
        rst = 1'b0;
        repeat (6) @(negedge bclk);
        check("rst_mid_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid_idle", 32'(bus.busy), 32'd0);
        run_vec(0);

        check("protocol", 32'(proto_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
